// File: rtl/color_seq_pkg.sv
// color_seq_pkg: shared state encoding and colour-table slice helper for the colour sequencer
package color_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    // Widest flat colour table the slice helper accepts; callers zero-extend into it.
    localparam int MAX_TABLE_W = 1024;

    // Returns colour slice k (w bits wide, w <= 32) of a flat table, zero-extended to 32 bits.
    function automatic logic [31:0] color_slice(input logic [MAX_TABLE_W-1:0] tbl, input int k, input int w);
        logic [MAX_TABLE_W-1:0] s;
        s = tbl >> (k * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: clearable, enabled up-counter that flags the last cycle of a programmable interval
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count to 0 (wins over en)
//   en         : advance the count by one
//   limit      : interval length in cycles (must be >= 1)
//   expire     : high while the count sits on limit-1
module seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expire
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = clr ? '0 : en ? count_q + WIDTH'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign expire = (count_q == limit - WIDTH'(1));

endmodule

// File: rtl/color_sequencer.sv
// color_sequencer: steps a registered LED colour through NUM_PHASES programmable phases
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : rising edge in IDLE (without stop) starts a run
//   stop         : synchronous abort back to IDLE
//   pause        : freezes the current phase while high
//   loop_en      : wrap to phase 0 after the last phase instead of finishing
//   dwell        : cycles per phase (0 treated as 1), latched on accepted start
//   phase_color  : flat colour table, slice k = phase k, latched on accepted start
//   color_out, phase_idx, busy, done : registered status and LED drive
module color_sequencer
    import color_seq_pkg::*;
#(
    parameter  int NUM_PHASES  = 3,
    parameter  int COLOR_WIDTH = 3,
    parameter  int DWELL_WIDTH = 16,
    localparam int IDX_WIDTH   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              pause,
    input  logic                              loop_en,
    input  logic [DWELL_WIDTH-1:0]            dwell,
    input  logic [NUM_PHASES*COLOR_WIDTH-1:0] phase_color,
    output logic [COLOR_WIDTH-1:0]            color_out,
    output logic [IDX_WIDTH-1:0]              phase_idx,
    output logic                              busy,
    output logic                              done
);

    localparam int TABLE_W = NUM_PHASES * COLOR_WIDTH;

    state_e                   state_q, state_d;
    logic                     start_q;
    logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
    logic [TABLE_W-1:0]       table_q, table_d;
    logic [IDX_WIDTH-1:0]     phase_idx_q, phase_idx_d;
    logic [COLOR_WIDTH-1:0]   color_q, color_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     timer_clr, timer_en, expire;
    logic                     start_edge, last_phase;

    assign start_edge = start & ~start_q;
    assign last_phase = (phase_idx_q == IDX_WIDTH'(NUM_PHASES - 1));

    seq_timer #(.WIDTH(DWELL_WIDTH)) u_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .limit  (dwell_q),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        table_d     = table_q;
        phase_idx_d = phase_idx_q;
        color_d     = color_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d      = 1'b0;
                phase_idx_d = '0;
                color_d     = '0;
                if (start_edge && !stop) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    dwell_d   = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
                    table_d   = phase_color;
                    color_d   = COLOR_WIDTH'(color_slice(MAX_TABLE_W'(phase_color), 0, COLOR_WIDTH));
                    timer_clr = 1'b1;
                end
            end
            RUN, PAUSED: begin
                if (stop) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    phase_idx_d = '0;
                    color_d     = '0;
                    timer_clr   = 1'b1;
                end else if (pause) begin
                    state_d = PAUSED;
                end else begin
                    // Counting resumes in the very cycle pause drops, even while still flagged PAUSED.
                    state_d = RUN;
                    if (!expire) begin
                        timer_en = 1'b1;
                    end else begin
                        timer_clr = 1'b1;
                        if (!last_phase) begin
                            phase_idx_d = phase_idx_q + IDX_WIDTH'(1);
                            color_d     = COLOR_WIDTH'(color_slice(MAX_TABLE_W'(table_q), int'(phase_idx_q) + 1, COLOR_WIDTH));
                        end else if (loop_en) begin
                            phase_idx_d = '0;
                            color_d     = COLOR_WIDTH'(color_slice(MAX_TABLE_W'(table_q), 0, COLOR_WIDTH));
                        end else begin
                            state_d     = IDLE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            phase_idx_d = '0;
                            color_d     = '0;
                        end
                    end
                end
            end
            default: begin
                state_d     = state_e'('x);
                phase_idx_d = 'x;
                color_d     = 'x;
                busy_d      = 1'bx;
                done_d      = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            dwell_q     <= '0;
            table_q     <= '0;
            phase_idx_q <= '0;
            color_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            dwell_q     <= dwell_d;
            table_q     <= table_d;
            phase_idx_q <= phase_idx_d;
            color_q     <= color_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign color_out = color_q;
    assign phase_idx = phase_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_color_sequencer.sv
// tb_color_sequencer: directed self-checking bench for color_sequencer with default parameters
module tb_color_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stop, pause, loop_en;
    logic [15:0] dwell;
    logic [8:0]  phase_color;
    logic [2:0]  color_out;
    logic [1:0]  phase_idx;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int cols [3] = '{1, 3, 2};

    color_sequencer #(.NUM_PHASES(3), .COLOR_WIDTH(3), .DWELL_WIDTH(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .dwell       (dwell),
        .phase_color (phase_color),
        .color_out   (color_out),
        .phase_idx   (phase_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {color_out, phase_idx, busy, done} against the expected tuple.
    task automatic chk(input string tag, input int c, input int i, input int b, input int d);
        logic [6:0] obs, exp;
        obs = {color_out, phase_idx, busy, done};
        exp = {3'(c), 2'(i), 1'(b), 1'(d)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed color=%b idx=%0d busy=%b done=%b, expected color=%b idx=%0d busy=%b done=%b",
                   tag, obs[6:4], obs[3:2], obs[1], obs[0], exp[6:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        dwell = 16'd3; phase_color = 9'b010_011_001;
        step(); step();
        chk("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", 0, 0, 0, 0);

        // One-shot run, 3 cycles per phase
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("oneshot", cols[i/3], i/3, 1, 0);
            step();
        end
        chk("oneshot_done", 0, 0, 0, 1);
        step();
        chk("oneshot_after", 0, 0, 0, 0);

        // Looping run, loop_en dropped at run cycle 20 (phase 0, last count)
        loop_en = 1'b1; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            if (i == 20) loop_en = 1'b0;
            chk("loop", cols[(i/3)%3], (i/3)%3, 1, 0);
            step();
        end
        chk("loop_done", 0, 0, 0, 1);
        step();
        chk("loop_after", 0, 0, 0, 0);

        // Pause for 5 cycles at count 1 of phase 1, dwell 4 -> phase 1 spans cycles 4..12
        dwell = 16'd4; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            int idx;
            idx = (i < 4) ? 0 : (i < 13) ? 1 : 2;
            pause = (i >= 5 && i <= 9);
            chk("pause", cols[idx], idx, 1, 0);
            step();
        end
        pause = 1'b0;
        chk("pause_done", 0, 0, 0, 1);
        step();

        // Stop together with pause while PAUSED; start stays high afterwards
        dwell = 16'd3; start = 1'b1; step();
        chk("sp_run", 1, 0, 1, 0);
        pause = 1'b1; step();
        chk("sp_paused", 1, 0, 1, 0);
        stop = 1'b1; step();
        chk("sp_stopped", 0, 0, 0, 0);
        stop = 1'b0; pause = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("no_retrigger", 0, 0, 0, 0);
            step();
        end
        start = 1'b0; step();
        start = 1'b1; step();
        chk("restart", 1, 0, 1, 0);
        step();
        chk("restart_hold", 1, 0, 1, 0);
        stop = 1'b1; step();
        chk("restart_stop", 0, 0, 0, 0);
        stop = 1'b0; start = 1'b0; step();

        // dwell 0 with start and stop together, then a clean start
        dwell = 16'd0; start = 1'b1; stop = 1'b1; step();
        chk("start_stop", 0, 0, 0, 0);
        start = 1'b0; stop = 1'b0; step();
        chk("start_stop_idle", 0, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("dwell0_p0", 1, 0, 1, 0);
        step();
        chk("dwell0_p1", 3, 1, 1, 0);
        step();
        chk("dwell0_p2", 2, 2, 1, 0);
        step();
        chk("dwell0_done", 0, 0, 0, 1);
        step();
        chk("dwell0_after", 0, 0, 0, 0);

        // Asynchronous reset during phase 1
        dwell = 16'd3; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_reset", 3, 1, 1, 0);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 0, 0, 0, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", 0, 0, 0, 0);
        end
        start = 1'b1; step(); start = 1'b0;
        chk("post_reset_start", 1, 0, 1, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
Parametrised successor to the fixed three-colour LED sequencer. Steps an output colour vector through NUM_PHASES programmable colour phases. Each phase lasts a run-time dwell count. Supports one-shot or looping runs, pause and abort. Sits between the debounced user-button logic and the LED pad drivers.

Parameters:
NUM_PHASES, 3, number of colour phases per run (>=1)
COLOR_WIDTH, 3, width of one colour code / LED output vector
DWELL_WIDTH, 16, width of dwell value and phase counter
IDX_WIDTH, $clog2(NUM_PHASES) min 1, width of phase index (localparam)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  run request level; a rising edge starts a run
stop  in  1  synchronous abort, level
pause  in  1  freeze current phase while high
loop_en  in  1  1 = wrap to phase 0 after last phase, 0 = one-shot
dwell  in  DWELL_WIDTH  cycles per phase; sampled on accepted start
phase_color  in  NUM_PHASES*COLOR_WIDTH  colour table; slice k = phase k; sampled on accepted start
color_out  out  COLOR_WIDTH  registered LED drive
phase_idx  out  IDX_WIDTH  current phase, registered
busy  out  1  high while RUN or PAUSED
done  out  1  one-cycle pulse at end of a one-shot run

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE; color_out, phase_idx, busy and done = 0; start edge register = 0; counter = 0.
- Start edge: start_q registered each cycle. start & ~start_q in IDLE with stop=0 is an accepted start.
- Accepted start at edge N. In cycle N+1: state RUN, busy=1, phase_idx=0, color_out=slice 0. dwell and the table are latched into internal registers.
- A start edge while busy is ignored. Holding start high does not retrigger.
- dwell=0 is treated as 1.
- RUN: counter increments each cycle and clears on every phase change. Phase ends when counter == dwell_q-1, giving exactly dwell_q cycles per phase.
- At phase end with phase_idx < NUM_PHASES-1: next cycle, phase_idx+1 and its colour.
- At phase end of the last phase:
  - loop_en=1 (sampled at that cycle): phase_idx=0, colour slice 0, no gap cycle.
  - loop_en=0: next cycle state IDLE, color_out=0, busy=0, done=1 for exactly one cycle.
- pause=1 in RUN: state PAUSED from next cycle. Counter, phase_idx and color_out hold. pause=0 returns to RUN and the count resumes where it stopped.
- stop=1 in RUN or PAUSED: next cycle IDLE, color_out=0, phase_idx=0, busy=0, done=0.
- Priority per cycle: stop > pause > phase-end > count.
- A start edge coincident with stop in IDLE is ignored.
- NUM_PHASES=1 degenerates to a single-colour timed pulse; loop_en=1 then holds the colour indefinitely.
- Invalid state encoding: next state and outputs = 'x (simulation aid). Synthesis is free to optimise.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package color_seq_pkg: state_e enum (IDLE, RUN, PAUSED) and a function extracting colour slice k from the flat table.
- Sub-module seq_timer: DWELL_WIDTH counter with clear/enable, producing the expire flag. Reusable by other timed blocks.

Test Plan:
- Reset mid-run: assert reset_n=0 during phase 1 -> all outputs 0 immediately; after release the block stays IDLE until a new start edge.
- One-shot run, NUM_PHASES=3, table {010,011,001}, dwell=3, loop_en=0, start pulse -> color_out 001 x3, 011 x3, 010 x3, then 000 with done=1 for one cycle; busy high for exactly 9 cycles.
- Loop run, same table, loop_en=1 for 20 cycles then 0 -> phase sequence 0,1,2,0,1,2,0,...; the run finishes at the first last-phase end after loop_en drops; done is pulsed once.
- Pause: dwell=4, pause high for 5 cycles at counter=1 of phase 1 -> colour 011 held 5 extra cycles; phase 1 lasts 9 cycles total.
- Stop and pause together during PAUSED, then start held high for 10 cycles while busy -> IDLE next cycle with done=0; no retrigger while start is held; a fresh edge restarts at phase 0.
- dwell=0 with start and stop in the same IDLE cycle -> no run; the next clean start gives 1-cycle phases (001, 011, 010, then done).
